// File: rtl/bin_to_bcd_seq_if.sv
// bin_to_bcd_seq_if: start/result bundle between a conversion requester and bin_to_bcd_seq
interface bin_to_bcd_seq_if #(
  parameter int WIDTH = 16
);
  logic start;
  logic [WIDTH-1:0] data_in;
  logic busy;
  logic done;
  logic [31:0] digits;
  logic [7:0] anodes_mask;
  modport master (output start, data_in, input busy, done, digits, anodes_mask);
  modport slave (input start, data_in, output busy, done, digits, anodes_mask);
endinterface

// File: rtl/bin_to_bcd_seq.sv
// bin_to_bcd_seq: iterative double-dabble binary-to-BCD converter with leading-zero blanked anode mask
module bin_to_bcd_seq #(
  parameter int WIDTH = 16,
  parameter int DIGITS = 5,
  parameter bit BLANK = 1'b1
) (
  input logic clk,
  input logic reset,
  bin_to_bcd_seq_if.slave bus
);
  localparam int CW = $clog2(WIDTH + 1);
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  state_t state;
  logic [WIDTH-1:0] bin;
  logic [CW-1:0] cnt;
  logic [4*DIGITS-1:0] bcd;
  logic [4*DIGITS-1:0] bcd_adj;
  logic [4*DIGITS-1:0] bcd_nxt;
  logic [DIGITS-1:0] nz;
  logic [7:0] mask;
  for (genvar i = 0; i < DIGITS; i++) begin : g_dig
    assign bcd_adj[4*i+:4] = bcd[4*i+:4] >= 4'd5 ? bcd[4*i+:4] + 4'd3 : bcd[4*i+:4];
    assign nz[i] = |bcd_nxt[4*i+:4];
  end
  assign bcd_nxt = (4*DIGITS)'({bcd_adj, bin[WIDTH-1]});
  always_comb begin
    mask = '0;
    for (int i = 0; i < DIGITS; i++) mask[i] = !BLANK || i == 0 || |(nz >> i);
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
      bin <= '0;
      bcd <= '0;
      cnt <= '0;
      bus.busy <= 1'b0;
      bus.done <= 1'b0;
      bus.digits <= '0;
      bus.anodes_mask <= 8'h01;
    end else begin
      bus.done <= 1'b0;
      case (state)
        IDLE: if (bus.start) begin
          state <= SHIFT;
          bin <= bus.data_in;
          bcd <= '0;
          cnt <= CW'(WIDTH);
          bus.busy <= 1'b1;
        end
        SHIFT: begin
          bcd <= bcd_nxt;
          bin <= bin << 1;
          cnt <= cnt - 1'b1;
          if (cnt == CW'(1)) begin
            state <= DONE;
            bus.done <= 1'b1;
            bus.digits <= 32'(bcd_nxt);
            bus.anodes_mask <= mask;
          end
        end
        default: begin
          state <= IDLE;
          bus.busy <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// tb_bin_to_bcd_seq: randomized self-checking bench for bin_to_bcd_seq against a decimal reference model
module tb_bin_to_bcd_seq;
  localparam int W = 16;
  localparam int LAT = W + 1;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int checks = 0;
  int fails = 0;
  bin_to_bcd_seq_if #(.WIDTH(W)) bus ();
  bin_to_bcd_seq_if #(.WIDTH(W)) bus2 ();
  bin_to_bcd_seq #(.WIDTH(W), .DIGITS(5), .BLANK(1'b1)) dut (.clk(clk), .reset(reset), .bus(bus));
  bin_to_bcd_seq #(.WIDTH(W), .DIGITS(5), .BLANK(1'b0)) dut2 (.clk(clk), .reset(reset), .bus(bus2));
  always #5 clk = ~clk;

  function automatic logic [31:0] ref_bcd(input int unsigned v);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < 8; i++) begin
      r[4*i+:4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  function automatic logic [7:0] ref_mask(input int unsigned v, input bit blank);
    int n;
    if (!blank) return 8'h1F;
    n = 1;
    while (v >= 10) begin
      v = v / 10;
      n++;
    end
    return 8'((1 << n) - 1);
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic launch(input logic [W-1:0] v);
    bus.data_in = v;
    bus.start = 1'b1;
    tick;
    bus.start = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b0;
    for (int e = 0; e < 3; e++) begin
      if (e == 2) reset = 1'b1;
      tick;
      checks++;
      if ({bus.busy, bus.done, bus.anodes_mask, bus.digits} !== {2'b00, 8'h01, 32'h0}) begin
        fails++;
        $display("FAIL reset[%0d]: busy=%b done=%b mask=%h digits=%h, want 0 0 01 00000000", e, bus.busy, bus.done, bus.anodes_mask, bus.digits);
      end
      checks++;
      if ({bus2.busy, bus2.done, bus2.anodes_mask, bus2.digits} !== {2'b00, 8'h01, 32'h0}) begin
        fails++;
        $display("FAIL reset_noblank[%0d]: busy=%b done=%b mask=%h digits=%h, want 0 0 01 00000000", e, bus2.busy, bus2.done, bus2.anodes_mask, bus2.digits);
      end
    end
  endtask

  task automatic test_max;
    launch(16'hFFFF);
    for (int k = 1; k <= LAT + 2; k++) begin
      checks++;
      if (bus.busy !== (k <= LAT) || bus.done !== (k == LAT)) begin
        fails++;
        $display("FAIL max_timing cycle %0d: busy=%b done=%b, want busy=%b done=%b", k, bus.busy, bus.done, k <= LAT, k == LAT);
      end
      if (k == LAT) begin
        checks++;
        if (bus.digits !== ref_bcd(65535) || bus.anodes_mask !== ref_mask(65535, 1'b1)) begin
          fails++;
          $display("FAIL max_value: digits=%h mask=%h, want %h %h", bus.digits, bus.anodes_mask, ref_bcd(65535), ref_mask(65535, 1'b1));
        end
      end
      tick;
    end
  endtask

  task automatic test_back_to_back;
    int n;
    launch(16'd1000);
    n = 0;
    while (bus.done !== 1'b1 && n < 40) begin
      tick;
      n++;
    end
    checks++;
    if (n != LAT - 1 || bus.digits !== ref_bcd(1000) || bus.anodes_mask !== ref_mask(1000, 1'b1)) begin
      fails++;
      $display("FAIL b2b_first: wait=%0d digits=%h mask=%h, want %0d %h %h", n, bus.digits, bus.anodes_mask, LAT - 1, ref_bcd(1000), ref_mask(1000, 1'b1));
    end
    tick;
    checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      fails++;
      $display("FAIL b2b_idle: busy=%b done=%b, want 0 0", bus.busy, bus.done);
    end
    launch(16'd0);
    n = 0;
    while (bus.done !== 1'b1 && n < 40) begin
      tick;
      n++;
    end
    checks++;
    if (n != LAT - 1 || bus.digits !== ref_bcd(0) || bus.anodes_mask !== ref_mask(0, 1'b1)) begin
      fails++;
      $display("FAIL b2b_second: wait=%0d digits=%h mask=%h, want %0d %h %h", n, bus.digits, bus.anodes_mask, LAT - 1, ref_bcd(0), ref_mask(0, 1'b1));
    end
    tick;
  endtask

  task automatic test_ignore_busy_start;
    int ndone;
    ndone = 0;
    launch(16'd1234);
    for (int k = 1; k <= 30; k++) begin
      if (bus.done === 1'b1) begin
        ndone++;
        checks++;
        if (k != LAT || bus.digits !== ref_bcd(1234) || bus.anodes_mask !== ref_mask(1234, 1'b1)) begin
          fails++;
          $display("FAIL ignore_result cycle %0d: digits=%h mask=%h, want cycle %0d %h %h", k, bus.digits, bus.anodes_mask, LAT, ref_bcd(1234), ref_mask(1234, 1'b1));
        end
      end
      if (k == 5) begin
        bus.data_in = 16'd9;
        bus.start = 1'b1;
      end
      tick;
      bus.start = 1'b0;
    end
    checks++;
    if (ndone != 1) begin
      fails++;
      $display("FAIL ignore_pulses: done pulses=%0d, want 1", ndone);
    end
    checks++;
    if (bus.digits !== ref_bcd(1234)) begin
      fails++;
      $display("FAIL ignore_hold: digits=%h, want %h", bus.digits, ref_bcd(1234));
    end
  endtask

  task automatic test_reset_mid;
    int ndone;
    int n;
    ndone = 0;
    launch(16'd4321);
    for (int k = 1; k < 8; k++) begin
      if (bus.done === 1'b1) ndone++;
      tick;
    end
    reset = 1'b0;
    tick;
    reset = 1'b1;
    checks++;
    if ({bus.busy, bus.done, bus.anodes_mask, bus.digits} !== {2'b00, 8'h01, 32'h0}) begin
      fails++;
      $display("FAIL midreset_state: busy=%b done=%b mask=%h digits=%h, want 0 0 01 00000000", bus.busy, bus.done, bus.anodes_mask, bus.digits);
    end
    for (int k = 0; k < 25; k++) begin
      if (bus.done === 1'b1 || bus.busy === 1'b1) ndone++;
      tick;
    end
    checks++;
    if (ndone != 0) begin
      fails++;
      $display("FAIL midreset_nodone: stray done/busy cycles=%0d, want 0", ndone);
    end
    launch(16'd4321);
    n = 0;
    while (bus.done !== 1'b1 && n < 40) begin
      tick;
      n++;
    end
    checks++;
    if (n != LAT - 1 || bus.digits !== ref_bcd(4321) || bus.anodes_mask !== ref_mask(4321, 1'b1)) begin
      fails++;
      $display("FAIL midreset_recover: wait=%0d digits=%h mask=%h, want %0d %h %h", n, bus.digits, bus.anodes_mask, LAT - 1, ref_bcd(4321), ref_mask(4321, 1'b1));
    end
    tick;
  endtask

  task automatic test_random;
    logic [31:0] prev;
    int unsigned v;
    int n;
    for (int t = 0; t < 25; t++) begin
      v = (t % 3 == 0) ? $urandom_range(0, 99) : $urandom_range(0, 65535);
      prev = bus.digits;
      launch(16'(v));
      n = 0;
      while (bus.done !== 1'b1 && n < 40) begin
        checks++;
        if (bus.digits !== prev) begin
          fails++;
          $display("FAIL random_hold value %0d: digits=%h, want %h", v, bus.digits, prev);
        end
        tick;
        n++;
      end
      checks++;
      if (n != LAT - 1 || bus.digits !== ref_bcd(v) || bus.anodes_mask !== ref_mask(v, 1'b1)) begin
        fails++;
        $display("FAIL random_result value %0d: wait=%0d digits=%h mask=%h, want %0d %h %h", v, n, bus.digits, bus.anodes_mask, LAT - 1, ref_bcd(v), ref_mask(v, 1'b1));
      end
      tick;
    end
  endtask

  task automatic test_blank_off;
    int unsigned v;
    int n;
    for (int t = 0; t < 4; t++) begin
      v = (t == 0) ? 7 : $urandom_range(0, 65535);
      bus2.data_in = 16'(v);
      bus2.start = 1'b1;
      tick;
      bus2.start = 1'b0;
      n = 0;
      while (bus2.done !== 1'b1 && n < 40) begin
        tick;
        n++;
      end
      checks++;
      if (n != LAT - 1 || bus2.digits !== ref_bcd(v) || bus2.anodes_mask !== ref_mask(v, 1'b0)) begin
        fails++;
        $display("FAIL noblank value %0d: wait=%0d digits=%h mask=%h, want %0d %h %h", v, n, bus2.digits, bus2.anodes_mask, LAT - 1, ref_bcd(v), ref_mask(v, 1'b0));
      end
      tick;
    end
  endtask

  initial begin
    bus.start = 1'b0;
    bus.data_in = '0;
    bus2.start = 1'b0;
    bus2.data_in = '0;
    test_reset;
    test_max;
    test_back_to_back;
    test_ignore_busy_start;
    test_reset_mid;
    test_random;
    test_blank_off;
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
